round_robin_arbiter: RTL
========================

Name: round_robin_arbiter

Overview:
- Parametrised, registered successor to the combinational fixed-priority arbiter.
- Grants one of NUM_PORTS requesters per transaction using rotating priority, so every requester is served within NUM_PORTS grants.
- Supports a downstream ready handshake and per-port lock for multi-beat bursts.
- Sits in core/control in front of shared resources (unified buffer ports, weight FIFO, host DMA).

Parameters:
- NUM_PORTS, 4: number of requesters; must be at least 1.
- MAX_HOLD, 16: consecutive locked transfers allowed before lock is overridden. Used only with the optional feature.
- IDX_W, $clog2(NUM_PORTS) (minimum 1): width of grant_index; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- requests  input  NUM_PORTS  per-port request; held until served.
- locks  input  NUM_PORTS  per-port burst lock; sampled only for the granted port.
- ready  input  1  downstream accepts the current granted beat this cycle.
- grants  output  NUM_PORTS  registered one-hot grant, or all-zero.
- grant_valid  output  1  OR of grants.
- grant_index  output  IDX_W  binary index of the granted port; 0 when no grant.

Behaviour:
- Reset (async assert, sync release): grants=0, grant_valid=0, grant_index=0, state=IDLE, ptr=0, hold_cnt=0.
- ptr is the highest-priority port for the next arbitration. Search order is ptr, ptr+1 … NUM_PORTS-1, 0 … ptr-1 (modulo wrap).
- States:
  - IDLE: no grant held.
  - BUSY: one port granted.
- IDLE:
  - If any request is high, the winner from the rotated search is registered next cycle (1-cycle latency). State goes to BUSY and ptr becomes (winner+1) mod NUM_PORTS.
  - Otherwise stay IDLE.
- BUSY, ready=0, granted request high: hold grants unchanged.
- BUSY, granted request dropped without ready:
  - Grant is withdrawn next cycle and state goes to IDLE.
  - ptr stays as already advanced; no new grant that cycle.
- BUSY, ready=1 (transfer), locks[granted]=1: grant stays on the same port and hold_cnt increments. Other requests are ignored.
- BUSY, ready=1 (transfer), locks[granted]=0:
  - Re-arbitrate the same cycle among current requests, including the just-served port, which has lowest priority through ptr.
  - If there is a winner: new grant registered next cycle with no bubble, ptr advances, hold_cnt=0.
  - If there is no winner: go IDLE with grants=0 next cycle.
- Grants are never two-hot. grant_index and grant_valid are registered together with grants, so all three are always consistent.
- NUM_PORTS=1: ptr stays 0; behaviour reduces to grant or hold.
- Wrap-around: winner NUM_PORTS-1 sets ptr to 0.
- Reset asserted mid-burst: all outputs clear immediately (asynchronously). After release, the first grant starts from port 0.

Optional Feature:
- Macro: ARB_HOLD_TIMEOUT_EN.
- Defined:
  - hold_cnt (width $clog2(MAX_HOLD+1)) counts locked transfers.
  - When hold_cnt==MAX_HOLD-1 and a locked transfer occurs, lock is treated as 0: normal re-arbitration, and the locked port loses priority.
  - Prevents starvation by unbounded bursts.
- Undefined: no hold_cnt register; locks are honoured indefinitely; MAX_HOLD is ignored.

Decomposition:
- Shared package arb_pkg:
  - arb_state_e enum (IDLE, BUSY).
  - Function onehot_to_idx.
- One natural sub-module, rr_priority_pick: combinational rotated search.
  - Inputs: requests, ptr. Outputs: one-hot winner, found.
  - Implement as a double-width masked fixed-priority search, reusing fixed_priority_arbiter twice: masked and unmasked requests.

Test Plan (NUM_PORTS=4, MAX_HOLD=4):
- Reset, then requests=4'b1111, ready=1, locks=0 held 8 cycles → grant_index 0,1,2,3,0,1,2,3 on consecutive cycles starting 1 cycle after requests; grant_valid=1 throughout.
- requests=4'b0100, ready=0 for 5 cycles, then ready=1 one cycle → grants=4'b0100 stable all 6 cycles, then 0 and IDLE; ptr=3, so next requests=4'b1001 grants port 3 first.
- Port 1 granted with locks=4'b0010, ready=1, requests=4'b1011 for 3 cycles → grants stays 4'b0010; on lock drop, next grant is port 3.
- With ARB_HOLD_TIMEOUT_EN: port 2 locked permanently, requests=4'b0101, ready=1 → port 2 holds exactly 4 transfers, then port 0 granted; without macro, port 2 holds for the whole 20-cycle window.
- Port 3 granted, ready=0, requests[3] dropped → grants=0 next cycle; IDLE; no other grant that cycle.
- rst_n pulsed low mid-burst (port 1 locked) → grants=0 immediately (asynchronous); after release with requests=4'b0010, port 1 is granted 1 cycle later.

Source files
------------

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the round-robin arbiter.
//   arb_state_e   : arbiter state (IDLE = no grant held, BUSY = one port granted)
//   MAX_PORTS     : widest one-hot vector onehot_to_idx can decode
//   onehot_to_idx : binary index of the set bit of a one-hot vector (0 if none)
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int MAX_PORTS = 64;

  function automatic int onehot_to_idx(input logic [MAX_PORTS-1:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (onehot[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fixed_priority_arbiter.sv
// -----------------------------------------------------------------------------
// fixed_priority_arbiter
// Combinational fixed-priority pick: the lowest-numbered active request wins.
//   req   [W-1:0] in  : request vector
//   gnt   [W-1:0] out : one-hot winner (all-zero when no request)
//   found         out : at least one request active
// -----------------------------------------------------------------------------
module fixed_priority_arbiter #(
  parameter int W = 4
) (
  input  logic [W-1:0] req,
  output logic [W-1:0] gnt,
  output logic         found
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnt   = req & (~req + W'(1));
  assign found = |req;

endmodule

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotated-priority search starting at ptr and wrapping around.
// The upper half of the search (ports >= ptr) is tried first via a masked
// fixed-priority pick; if empty, the unmasked pick covers the wrapped part.
//   requests [N-1:0]     in  : request vector
//   ptr      [IDX_W-1:0] in  : highest-priority port
//   winner   [N-1:0]     out : one-hot winner (all-zero when none)
//   found                out : some request is active
// -----------------------------------------------------------------------------
module rr_priority_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] requests,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] winner,
  output logic                 found
);

  logic [NUM_PORTS-1:0] mask;
  logic [NUM_PORTS-1:0] masked_req;
  logic [NUM_PORTS-1:0] masked_gnt;
  logic [NUM_PORTS-1:0] unmasked_gnt;
  logic                 masked_found;
  logic                 unmasked_found;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_mask
    assign mask[gi] = (ptr <= IDX_W'(gi));
  end

  assign masked_req = requests & mask;

  fixed_priority_arbiter #(.W(NUM_PORTS)) u_masked (
    .req   (masked_req),
    .gnt   (masked_gnt),
    .found (masked_found)
  );

  fixed_priority_arbiter #(.W(NUM_PORTS)) u_unmasked (
    .req   (requests),
    .gnt   (unmasked_gnt),
    .found (unmasked_found)
  );

  assign winner = masked_found ? masked_gnt : unmasked_gnt;
  assign found  = unmasked_found;

endmodule

// File: rtl/round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// round_robin_arbiter
// Registered rotating-priority arbiter with ready handshake and burst lock.
//   clk         in  : clock
//   rst_n       in  : asynchronous active-low reset
//   requests    in  : per-port request, held until served
//   locks       in  : per-port burst lock, only looked at for the granted port
//   ready       in  : downstream accepts the granted beat this cycle
//   grants      out : registered one-hot grant or zero
//   grant_valid out : OR of grants
//   grant_index out : binary index of granted port, 0 when none
// Optional build macro ARB_HOLD_TIMEOUT_EN: bounds a locked burst to MAX_HOLD
// transfers, after which the lock is ignored and normal re-arbitration runs.
// -----------------------------------------------------------------------------
module round_robin_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int MAX_HOLD  = 16,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] requests,
  input  logic [NUM_PORTS-1:0] locks,
  input  logic                 ready,
  output logic [NUM_PORTS-1:0] grants,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_index
);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grants_q, grants_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]     grant_index_q, grant_index_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
`endif

  logic [NUM_PORTS-1:0] winner;
  logic                 found;
  logic [IDX_W-1:0]     winner_idx;
  logic [IDX_W-1:0]     next_ptr;
  logic                 granted_req;
  logic                 lock_eff;
  logic                 rearb;
  logic                 release_grant;

  rr_priority_pick #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_pick (
    .requests (requests),
    .ptr      (ptr_q),
    .winner   (winner),
    .found    (found)
  );

  always_comb begin
    winner_idx = IDX_W'(onehot_to_idx(MAX_PORTS'(winner)));
    // Pointer moves just past the winner so it becomes lowest priority.
    if (winner_idx == IDX_W'(NUM_PORTS - 1)) next_ptr = '0;
    else                                     next_ptr = winner_idx + 1'b1;
  end

  assign granted_req = |(requests & grants_q);

  always_comb begin
    lock_eff = |(locks & grants_q);
`ifdef ARB_HOLD_TIMEOUT_EN
    // Last allowed locked transfer: behave as if the lock were released.
    if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) lock_eff = 1'b0;
`endif
  end

  always_comb begin
    state_d       = state_q;
    grants_d      = grants_q;
    grant_valid_d = grant_valid_q;
    grant_index_d = grant_index_q;
    ptr_d         = ptr_q;
`ifdef ARB_HOLD_TIMEOUT_EN
    hold_cnt_d    = hold_cnt_q;
`endif
    rearb         = 1'b0;
    release_grant = 1'b0;

    case (state_q)
      IDLE: rearb = 1'b1;
      BUSY: begin
        if (ready) begin
          if (lock_eff) begin
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_cnt_d = hold_cnt_q + 1'b1;
`endif
          end else begin
            rearb = 1'b1;
          end
        end else if (!granted_req) begin
          // Requester gave up before the beat was accepted.
          release_grant = 1'b1;
        end
      end
      default: release_grant = 1'b1;
    endcase

    if (rearb) begin
      if (found) begin
        state_d       = BUSY;
        grants_d      = winner;
        grant_valid_d = 1'b1;
        grant_index_d = winner_idx;
        ptr_d         = next_ptr;
`ifdef ARB_HOLD_TIMEOUT_EN
        hold_cnt_d    = '0;
`endif
      end else begin
        release_grant = 1'b1;
      end
    end

    if (release_grant) begin
      state_d       = IDLE;
      grants_d      = '0;
      grant_valid_d = 1'b0;
      grant_index_d = '0;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_cnt_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grants_q      <= '0;
      grant_valid_q <= 1'b0;
      grant_index_q <= '0;
      ptr_q         <= '0;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      grants_q      <= grants_d;
      grant_valid_q <= grant_valid_d;
      grant_index_q <= grant_index_d;
      ptr_q         <= ptr_d;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_cnt_q    <= hold_cnt_d;
`endif
    end
  end

  assign grants      = grants_q;
  assign grant_valid = grant_valid_q;
  assign grant_index = grant_index_q;

endmodule
